// File: rtl/bidir_pio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bidir_pio_pkg
//  Purpose  : Shared constants for the bidirectional PIO: Avalon register map
//             and edge-capture mode encodings.
//  Revision : 1.0  initial release
// ============================================================================
package bidir_pio_pkg;

    typedef logic [2:0] pio_addr_t;

    // Avalon word addresses of the register map
    localparam pio_addr_t ADDR_DATA = 3'd0;  // write: data_out, read: synced pins
    localparam pio_addr_t ADDR_DIR  = 3'd1;  // direction, 1 = drive
    localparam pio_addr_t ADDR_MASK = 3'd2;  // interrupt mask
    localparam pio_addr_t ADDR_EDGE = 3'd3;  // edge capture, write-1-to-clear
    localparam pio_addr_t ADDR_SET  = 3'd4;  // data_out |= wd
    localparam pio_addr_t ADDR_CLR  = 3'd5;  // data_out &= ~wd

    // Edge capture mode encodings
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage : bidir_pio_pkg
`default_nettype wire

// File: rtl/bidir_pio_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : bidir_pio_gen_if
//  Purpose  : Avalon-MM slave bus bundle plus interrupt line for the PIO.
//  Revision : 1.0  initial release
// ============================================================================
interface bidir_pio_gen_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    // Bus master / interrupt consumer side
    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata,
        input  irq
    );

    // PIO side
    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output irq
    );

endinterface : bidir_pio_gen_if
`default_nettype wire

// File: rtl/bidir_pio_sync.sv
`default_nettype none
// ============================================================================
//  Module   : bidir_pio_sync
//  Purpose  : WIDTH x SYNC_STAGES metastability flop chain for the pin inputs,
//             plus one extra delayed copy used for edge detection.
//  Revision : 1.0  initial release
// ============================================================================
module bidir_pio_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  wire  [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_q,
    output logic [WIDTH-1:0] prev_q
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_d;
    logic [WIDTH-1:0]                  prev_d;

    // Shift the raw pins into stage 0; last stage feeds the delayed copy
    always_comb begin
        chain_d = {chain_q[SYNC_STAGES-2:0], async_in};
        prev_d  = chain_q[SYNC_STAGES-1];
    end

    // Synchroniser and delay flops, cleared on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain_q <= '0;
            prev_q  <= '0;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
        end
    end

    assign sync_q = chain_q[SYNC_STAGES-1];

endmodule : bidir_pio_sync
`default_nettype wire

// File: rtl/bidir_pio_gen.sv
`default_nettype none
// ============================================================================
//  Module   : bidir_pio_gen
//  Purpose  : Parametrised bidirectional PIO with Avalon-MM slave: per-bit
//             direction, set/clear writes, optional open-drain drive, input
//             synchroniser, per-bit edge capture and a maskable level IRQ.
//  Revision : 1.0  initial release
// ============================================================================
module bidir_pio_gen
    import bidir_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter int               EDGE_TYPE   = 0,
    parameter int               OPEN_DRAIN  = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    bidir_pio_gen_if.slave   bus,
    inout  wire  [WIDTH-1:0] bidir_port
);

    // Edge detection stays disabled until the synchroniser has flushed its
    // reset zeros, so pins that are already high do not look like a rise.
    localparam logic [2:0] ARM_COUNT = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] data_dir_q, data_dir_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q,      irq_d;
    logic [2:0]       arm_cnt_q,  arm_cnt_d;
    logic             armed_q,    armed_d;

    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] det;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] wd;
    logic             wr;

    // Upper writedata bits beyond WIDTH are deliberately dropped
    logic unused_wd;
    assign unused_wd = ^bus.writedata;

    bidir_pio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (bidir_port),
        .sync_q   (sync_q),
        .prev_q   (prev_q)
    );

    // Pin drivers: push-pull follows data_out, open-drain only pulls low
    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        if (OPEN_DRAIN != 0) begin : g_od
            assign bidir_port[i] = (data_dir_q[i] & ~data_out_q[i]) ? 1'b0 : 1'bz;
        end else begin : g_pp
            assign bidir_port[i] = data_dir_q[i] ? data_out_q[i] : 1'bz;
        end
    end

    // Arming counter: saturates once the sync chain holds real pin data
    always_comb begin
        arm_cnt_d = (arm_cnt_q == ARM_COUNT) ? arm_cnt_q : arm_cnt_q + 3'd1;
        armed_d   = (arm_cnt_d == ARM_COUNT);
    end

    // Edge detector selected by EDGE_TYPE, gated until armed
    always_comb begin
        rise = sync_q & ~prev_q;
        fall = ~sync_q & prev_q;
        case (EDGE_TYPE)
            EDGE_FALL: det = fall;
            EDGE_ANY:  det = rise | fall;
            default:   det = rise;
        endcase
        det = det & {WIDTH{armed_q}};
    end

    // Register writes; a new edge on a bit overrides a same-cycle W1C clear
    always_comb begin
        wr         = bus.chipselect & ~bus.write_n;
        wd         = bus.writedata[WIDTH-1:0];
        data_out_d = data_out_q;
        data_dir_d = data_dir_q;
        irq_mask_d = irq_mask_q;
        edge_clr   = '0;
        if (wr) begin
            case (bus.address)
                ADDR_DATA: data_out_d = wd;
                ADDR_DIR:  data_dir_d = wd;
                ADDR_MASK: irq_mask_d = wd;
                ADDR_EDGE: edge_clr   = wd;
                ADDR_SET:  data_out_d = data_out_q | wd;
                ADDR_CLR:  data_out_d = data_out_q & ~wd;
                default:   ;
            endcase
        end
        edge_cap_d = (edge_cap_q & ~edge_clr) | det;
    end

    // Read mux and interrupt, both registered every cycle
    always_comb begin
        readdata_d = '0;
        case (bus.address)
            ADDR_DATA: readdata_d[WIDTH-1:0] = sync_q;
            ADDR_DIR:  readdata_d[WIDTH-1:0] = data_dir_q;
            ADDR_MASK: readdata_d[WIDTH-1:0] = irq_mask_q;
            ADDR_EDGE: readdata_d[WIDTH-1:0] = edge_cap_q;
            default:   ;
        endcase
        irq_d = |(edge_cap_q & irq_mask_q);
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q <= RESET_VALUE;
            data_dir_q <= '0;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
            arm_cnt_q  <= '0;
            armed_q    <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            data_dir_q <= data_dir_d;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
            arm_cnt_q  <= arm_cnt_d;
            armed_q    <= armed_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = irq_q;

endmodule : bidir_pio_gen
`default_nettype wire

// File: tb/tb_bidir_pio_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bidir_pio_gen
//  Purpose  : Directed self-checking bench for bidir_pio_gen. Three instances:
//             push-pull rising-edge (8 bits), open-drain (1 bit, pulled up),
//             any-edge (8 bits).
//  Revision : 1.0  initial release
// ============================================================================
module tb_bidir_pio_gen;

    logic clk;
    logic reset_n;

    logic [2:0]  tb_addr;
    logic [2:0]  tb_cs;     // bit0: dut0, bit1: dut_od, bit2: dut_any
    logic        tb_wn;
    logic [31:0] tb_wd;

    logic [7:0]  tb_en0,    tb_val0;
    logic [7:0]  tb_en_any, tb_val_any;

    int checks;
    int failures;

    wire [7:0] pins0;
    wire       pins_od;
    wire [7:0] pins_any;

    bidir_pio_gen_if bus0 ();
    bidir_pio_gen_if bus_od ();
    bidir_pio_gen_if bus_any ();

    assign bus0.address    = tb_addr;
    assign bus0.chipselect = tb_cs[0];
    assign bus0.write_n    = tb_wn;
    assign bus0.writedata  = tb_wd;

    assign bus_od.address    = tb_addr;
    assign bus_od.chipselect = tb_cs[1];
    assign bus_od.write_n    = tb_wn;
    assign bus_od.writedata  = tb_wd;

    assign bus_any.address    = tb_addr;
    assign bus_any.chipselect = tb_cs[2];
    assign bus_any.write_n    = tb_wn;
    assign bus_any.writedata  = tb_wd;

    // External pin drivers
    for (genvar i = 0; i < 8; i++) begin : g_tb_drv
        assign pins0[i]    = tb_en0[i]    ? tb_val0[i]    : 1'bz;
        assign pins_any[i] = tb_en_any[i] ? tb_val_any[i] : 1'bz;
    end

    // Board pull-up on the open-drain line
    pullup (pins_od);

    bidir_pio_gen #(
        .WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .OPEN_DRAIN(0), .RESET_VALUE(8'h00)
    ) u_dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0.slave), .bidir_port(pins0)
    );

    bidir_pio_gen #(
        .WIDTH(1), .SYNC_STAGES(2), .EDGE_TYPE(0), .OPEN_DRAIN(1), .RESET_VALUE(1'b0)
    ) u_dut_od (
        .clk(clk), .reset_n(reset_n), .bus(bus_od.slave), .bidir_port(pins_od)
    );

    bidir_pio_gen #(
        .WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2), .OPEN_DRAIN(0), .RESET_VALUE(8'h00)
    ) u_dut_any (
        .clk(clk), .reset_n(reset_n), .bus(bus_any.slave), .bidir_port(pins_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Single-cycle write, issued at a negedge, committed at the next posedge
    task automatic wr(input logic [2:0] sel, input logic [2:0] a, input logic [31:0] d);
        tb_cs   = sel;
        tb_wn   = 1'b0;
        tb_addr = a;
        tb_wd   = d;
        @(negedge clk);
        tb_cs   = 3'b000;
        tb_wn   = 1'b1;
    endtask

    // Present an address; registered readdata is valid at the next negedge
    task automatic rd(input logic [2:0] a);
        tb_addr = a;
        @(negedge clk);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset_n    = 1'b0;
        tb_addr    = 3'd0;
        tb_cs      = 3'b000;
        tb_wn      = 1'b1;
        tb_wd      = 32'h0;
        tb_en0     = 8'hFF;
        tb_val0    = 8'hFF;
        tb_en_any  = 8'hFF;
        tb_val_any = 8'h00;

        // ---- Reset with pins held high ----
        repeat (2) @(negedge clk);
        chk("rst_readdata", bus0.readdata, 32'h0);
        chk("rst_irq", {31'h0, bus0.irq}, 32'h0);
        chk("rst_pin_od_released", {31'h0, pins_od}, 32'h1);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        rd(3'd3);
        chk("arm_no_false_edge", bus0.readdata, 32'h00);
        rd(3'd0);
        chk("sync_reads_pins", bus0.readdata, 32'hFF);

        // ---- Push-pull drive with set / clear ----
        tb_en0 = 8'h00;
        wr(3'b001, 3'd1, 32'hFF);
        wr(3'b001, 3'd0, 32'hA5);
        chk("pins_data_a5", {24'h0, pins0}, 32'hA5);
        wr(3'b001, 3'd4, 32'h0A);
        chk("pins_set_af", {24'h0, pins0}, 32'hAF);
        wr(3'b001, 3'd5, 32'h21);
        chk("pins_clr_8e", {24'h0, pins0}, 32'h8E);
        tb_addr = 3'd0;
        repeat (2) @(negedge clk);
        chk("readback_lat2_old", bus0.readdata, 32'hAF);
        @(negedge clk);
        chk("readback_lat3_new", bus0.readdata, 32'h8E);
        rd(3'd1);
        chk("read_dir", bus0.readdata, 32'hFF);

        // ---- Input mode, falling edge ignored in rising mode ----
        tb_val0 = 8'h8E;
        tb_en0  = 8'hFF;
        wr(3'b001, 3'd1, 32'h00);
        wr(3'b001, 3'd3, 32'hFF);
        tb_val0 = 8'h00;
        repeat (5) @(negedge clk);
        rd(3'd3);
        chk("fall_not_captured", bus0.readdata, 32'h00);

        // ---- Rising edge on pin0, interrupt and W1C ----
        wr(3'b001, 3'd2, 32'h01);
        rd(3'd2);
        chk("read_mask", bus0.readdata, 32'h01);
        chk("irq_idle", {31'h0, bus0.irq}, 32'h0);
        tb_addr = 3'd3;
        tb_val0 = 8'h01;
        repeat (3) @(negedge clk);
        chk("edge_cap_not_yet", bus0.readdata, 32'h00);
        chk("irq_not_yet", {31'h0, bus0.irq}, 32'h0);
        @(negedge clk);
        chk("edge_cap_pin0", bus0.readdata, 32'h01);
        chk("irq_asserted", {31'h0, bus0.irq}, 32'h1);
        wr(3'b001, 3'd3, 32'h01);
        chk("irq_held_clr_cycle", {31'h0, bus0.irq}, 32'h1);
        @(negedge clk);
        chk("irq_cleared", {31'h0, bus0.irq}, 32'h0);

        // ---- Pin3 rise collides with W1C of bit 3: set wins ----
        tb_val0 = 8'h09;
        repeat (2) @(negedge clk);
        wr(3'b001, 3'd3, 32'h08);
        rd(3'd3);
        chk("set_beats_clear", bus0.readdata, 32'h08);
        chk("irq_masked_off", {31'h0, bus0.irq}, 32'h0);
        wr(3'b001, 3'd2, 32'h08);
        chk("irq_mask_lat0", {31'h0, bus0.irq}, 32'h0);
        @(negedge clk);
        chk("irq_mask_lat1", {31'h0, bus0.irq}, 32'h1);

        // ---- Open-drain instance ----
        chk("od_released", {31'h0, pins_od}, 32'h1);
        wr(3'b010, 3'd1, 32'h01);
        chk("od_drive_low", {31'h0, pins_od}, 32'h0);
        wr(3'b010, 3'd0, 32'hFFFF_FFFF);
        chk("od_release_high", {31'h0, pins_od}, 32'h1);
        tb_addr = 3'd0;
        repeat (3) @(negedge clk);
        chk("od_read_pullup", bus_od.readdata, 32'h1);
        wr(3'b010, 3'd0, 32'hFFFF_FFFE);
        chk("od_low_again", {31'h0, pins_od}, 32'h0);
        wr(3'b010, 3'd1, 32'hFFFF_FFFF);
        rd(3'd1);
        chk("od_upper_bits_dropped", bus_od.readdata, 32'h1);

        // ---- Any-edge instance: both edges of pin7 captured ----
        wr(3'b100, 3'd3, 32'hFF);
        tb_val_any = 8'h80;
        repeat (4) @(negedge clk);
        rd(3'd3);
        chk("any_rise_pin7", bus_any.readdata, 32'h80);
        wr(3'b100, 3'd3, 32'h80);
        rd(3'd3);
        chk("any_cleared", bus_any.readdata, 32'h00);
        tb_val_any = 8'h00;
        repeat (4) @(negedge clk);
        rd(3'd3);
        chk("any_fall_pin7", bus_any.readdata, 32'h80);
        rd(3'd6);
        chk("read_addr6_zero", bus_any.readdata, 32'h0);
        rd(3'd7);
        chk("read_addr7_zero", bus_any.readdata, 32'h0);

        // ---- Asynchronous reset mid-cycle ----
        rd(3'd2);
        chk("pre_reset_mask", bus0.readdata, 32'h08);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_readdata", bus0.readdata, 32'h0);
        chk("async_rst_irq", {31'h0, bus0.irq}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        rd(3'd3);
        chk("rearm_no_false_edge", bus0.readdata, 32'h00);
        rd(3'd0);
        chk("post_reset_sync", bus0.readdata, 32'h09);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bidir_pio_gen
`default_nettype wire

// File: doc/bidir_pio_gen.md
Name: bidir_pio_gen

Overview:
- Parametrised bidirectional PIO with an Avalon-MM slave, one clock domain; successor to the single-bit RTC_SDA/SCL-style pins.
- Provides WIDTH pins with per-bit direction, set/clear output writes, and optional open-drain drive, suitable for I2C lines.
- Adds a metastability synchroniser, per-bit edge capture and a maskable level interrupt to the HPS/Nios IRQ fabric.
- Sits in soc_system between the lightweight bridge and the board pins.

Parameters:
- WIDTH, 8, number of pins (1..32).
- SYNC_STAGES, 2, input synchroniser depth (2..4).
- EDGE_TYPE, 0, capture mode: 0 rising, 1 falling, 2 any edge.
- OPEN_DRAIN, 0, 1 = drive low or release (Z) only; 0 = push-pull.
- RESET_VALUE, 0, reset value of the output data register (WIDTH bits).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- address  input  3  Avalon word address
- chipselect  input  1  slave select
- write_n  input  1  active-low write strobe
- writedata  input  32  write data; bits above WIDTH are ignored
- readdata  output  32  registered read data; bits above WIDTH read 0
- irq  output  1  level interrupt, active high
- bidir_port  inout  WIDTH  pins

Behaviour:
- Reset is asynchronous and active-low on reset_n; clock is clk.
- Reset values: data_out=RESET_VALUE, data_dir=0 (all pins Z), irq_mask=0, edge_cap=0, readdata=0, sync chain=0, armed=0.
- wr = chipselect & ~write_n. Write addresses:
  - 0: data_out <= wd
  - 1: data_dir <= wd
  - 2: irq_mask <= wd
  - 3: edge_cap <= edge_cap & ~wd (write-1-to-clear)
  - 4: data_out |= wd
  - 5: data_out &= ~wd
  - 6, 7: ignored
- Read mux, registered every cycle regardless of chipselect; readdata reflects the address one clock later:
  - 0: synchronised pin value (sync_q)
  - 1: data_dir
  - 2: irq_mask
  - 3: edge_cap
  - 4..7: 0
- Pin drive, per bit i:
  - Push-pull: pin = data_dir[i] ? data_out[i] : Z.
  - Open-drain: pin = (data_dir[i] & ~data_out[i]) ? 0 : Z.
- Input path: bidir_port passes through SYNC_STAGES flops to sync_q; prev_q is sync_q delayed by one cycle. A pin change appears in sync_q after SYNC_STAGES cycles.
- Edge detect:
  - rise = sync_q & ~prev_q; fall = ~sync_q & prev_q; any = rise | fall.
  - Gated by armed: a 3-bit counter runs from reset and sets armed after SYNC_STAGES+1 cycles. Pins high at reset therefore produce no spurious edge. The counter saturates.
- edge_cap[i] <= edge_cap[i] | det[i] each cycle.
- Simultaneous edge and W1C clear on the same bit in the same cycle: the set wins and the bit stays 1.
- irq = |(edge_cap & irq_mask), registered: asserts one cycle after edge_cap/mask change and deasserts one cycle after clear.
- Own driven pins loop back through the sync path, so outputs are readable at address 0 and can self-trigger edges.
- Reset mid-transfer: all state returns to reset values immediately, pins release to Z, and armed restarts.
- writedata bits at and above WIDTH are discarded. WIDTH=32 uses the full bus.

Decomposition:
- Package bidir_pio_pkg holds:
  - address constants: ADDR_DATA=0, ADDR_DIR=1, ADDR_MASK=2, ADDR_EDGE=3, ADDR_SET=4, ADDR_CLR=5
  - EDGE_RISE/EDGE_FALL/EDGE_ANY encodings
- Sub-module bidir_pio_sync: a WIDTH×SYNC_STAGES flop chain with async reset, outputs sync_q and prev_q.

Test Plan (WIDTH=8, SYNC_STAGES=2, EDGE_TYPE=0, OPEN_DRAIN=0):
- Reset with pins pulled to 0xFF → readdata=0, irq=0, pins Z, edge_cap stays 0x00 after 10 cycles (arming suppresses a false edge).
- Write dir=0xFF, data=0xA5, then set(4)=0x0A, then clr(5)=0x21 → pins 0xAF then 0x8E; read addr 0 returns 0x8E after 3 cycles.
- dir=0, mask=0x01, external pin0 driven 0→1 → edge_cap=0x01 three cycles later, irq=1 the next cycle; write 0x01 to addr 3 → irq=0 one cycle after.
- Pin3 rises in the same cycle that addr 3 is written with 0x08 → edge_cap[3]=1 (set beats clear).
- OPEN_DRAIN=1, dir=0x01, data=0x00 → pin0=0; data=0x01 → pin0=Z and reads pulled-up 1.
- EDGE_TYPE=2, toggle pin7 0→1→0 with a clear in between → edge_cap[7] set on both edges; reads of addresses 6 and 7 return 0.
